fc_neuron_seq: RTL and testbench

FC_NEURON_SEQ -- requirements
Module: fc_neuron_seq

---
 rtl/fc_neuron_seq.sv | 120 ++++++++++++
 tb/tb_fc_neuron_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_neuron_seq.sv
// Sequential fully-connected neuron: consumes IN activations as LANES-wide
// beats, multiplies them by constant weights and accumulates onto BIAS.
// When the last beat arrives it presents the result (optionally ReLU'd) and
// holds it until the consumer takes it.
module fc_neuron_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IN    = 128,
  parameter int unsigned LANES = 4,
  localparam int unsigned ACC_W = 2*WIDTH + $clog2(IN) + 1,
  parameter logic [IN*WIDTH-1:0]    WEIGHTS = '0,
  parameter logic signed [ACC_W-1:0] BIAS   = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*WIDTH-1:0]    in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic                      flush,
  output logic signed [ACC_W-1:0]   z,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned BEATS = IN / LANES;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {
    ST_ACCUM,
    ST_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [BW-1:0]            b_q, b_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  z_q, z_d;
  logic                     mode_q, mode_d;

  logic signed [WIDTH-1:0]   lane_x;
  logic signed [WIDTH-1:0]   lane_w;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   beat_sum;
  logic signed [ACC_W-1:0]   final_sum;
  logic                      eff_mode;
  int unsigned               idx;

  // Dot product of the current beat against the weight slice selected by b.
  always_comb begin
    lane_x   = '0;
    lane_w   = '0;
    prod     = '0;
    idx      = 0;
    beat_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx      = (32'(b_q) * LANES + l) * WIDTH;
      lane_x   = $signed(in_data[l*WIDTH +: WIDTH]);
      lane_w   = $signed(WEIGHTS[idx +: WIDTH]);
      prod     = lane_x * lane_w;
      beat_sum = beat_sum + ACC_W'(prod);
    end
  end

  // Next-state logic: accumulate beats, latch result, wait for handshake.
  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    acc_d     = acc_q;
    z_d       = z_q;
    mode_d    = mode_q;
    final_sum = acc_q + beat_sum;
    // A one-beat neuron must use the live mode, not the stale register.
    eff_mode  = (b_q == '0) ? mode : mode_q;
    case (state_q)
      ST_ACCUM: begin
        if (flush) begin
          b_d   = '0;
          acc_d = BIAS;
        end else if (in_valid) begin
          if (b_q == '0) mode_d = mode;
          if (b_q == LAST_BEAT) begin
            state_d = ST_DONE;
            b_d     = '0;
            acc_d   = BIAS;
            z_d     = (eff_mode && final_sum[ACC_W-1]) ? '0 : final_sum;
          end else begin
            b_d   = b_q + 1'b1;
            acc_d = final_sum;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State registers with asynchronous reset discarding all partial work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ACCUM;
      b_q     <= '0;
      acc_q   <= BIAS;
      z_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ST_ACCUM) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign z         = z_q;

endmodule

// File: tb/tb_fc_neuron_seq.sv
// Bench for fc_neuron_seq: five instances with different weights/bias share
// one stimulus stream; a queue-based reference model predicts each result.
module tb_fc_neuron_seq;

  localparam int NI = 5;
  localparam int N  = 8;
  localparam int AW = 20;
  localparam logic [63:0] WV0 = {8{8'h01}};
  localparam logic [63:0] WV1 = {8{8'hFF}};
  localparam logic [63:0] WV2 = {8{8'hFF}};
  localparam logic [63:0] WV3 = {8{8'h80}};
  localparam logic [63:0] WV4 = 64'h807F01FF05F613C3;

  logic clk = 1'b0;
  logic rst, mode, flush, in_valid, out_ready;
  logic [15:0] in_data;
  logic in_ready [NI];
  logic out_valid [NI];
  logic [AW-1:0] z [NI];

  int errors = 0;
  int checks = 0;

  logic [63:0] wv [NI];
  int bias [NI];
  int xs [$];
  bit m_done;
  bit m_mode;
  int exp_z [NI];

  always #5 clk = ~clk;

  fc_neuron_seq #(.WIDTH(8), .IN(8), .LANES(2), .WEIGHTS(WV0), .BIAS(20'sd0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[0]),
    .mode(mode), .flush(flush), .z(z[0]), .out_valid(out_valid[0]), .out_ready(out_ready));
  fc_neuron_seq #(.WIDTH(8), .IN(8), .LANES(2), .WEIGHTS(WV1), .BIAS(20'sd0)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[1]),
    .mode(mode), .flush(flush), .z(z[1]), .out_valid(out_valid[1]), .out_ready(out_ready));
  fc_neuron_seq #(.WIDTH(8), .IN(8), .LANES(2), .WEIGHTS(WV2), .BIAS(20'sd40)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[2]),
    .mode(mode), .flush(flush), .z(z[2]), .out_valid(out_valid[2]), .out_ready(out_ready));
  fc_neuron_seq #(.WIDTH(8), .IN(8), .LANES(2), .WEIGHTS(WV3), .BIAS(20'sd0)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[3]),
    .mode(mode), .flush(flush), .z(z[3]), .out_valid(out_valid[3]), .out_ready(out_ready));
  fc_neuron_seq #(.WIDTH(8), .IN(8), .LANES(2), .WEIGHTS(WV4), .BIAS(-20'sd77)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready[4]),
    .mode(mode), .flush(flush), .z(z[4]), .out_valid(out_valid[4]), .out_ready(out_ready));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic int zval(input int k);
    return int'($signed(z[k]));
  endfunction

  // Dot product of the collected activations with instance k's weights.
  function automatic int ref_z(input int k);
    int acc;
    logic [63:0] v;
    logic [7:0] wb;
    v   = wv[k];
    acc = bias[k];
    for (int i = 0; i < N; i++) begin
      wb  = v[i*8 +: 8];
      acc += int'($signed(wb)) * xs[i];
    end
    if (m_mode && acc < 0) acc = 0;
    return acc;
  endfunction

  // Advance the model by one clock with the current inputs, then compare.
  task automatic tick();
    logic [7:0] a0, a1;
    if (!m_done) begin
      if (flush) begin
        xs.delete();
      end else if (in_valid) begin
        if (xs.size() == 0) m_mode = mode;
        a0 = in_data[7:0];
        a1 = in_data[15:8];
        xs.push_back(int'($signed(a0)));
        xs.push_back(int'($signed(a1)));
        if (xs.size() == N) begin
          m_done = 1'b1;
          for (int k = 0; k < NI; k++) exp_z[k] = ref_z(k);
          xs.delete();
        end
      end
    end else if (out_ready) begin
      m_done = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_done));
      chk($sformatf("in_ready[%0d]", k), 32'(in_ready[k]), 32'(!m_done));
      if (m_done) chk($sformatf("z[%0d]", k), 32'($signed(z[k])), exp_z[k]);
    end
  endtask

  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic v);
    in_data  = {b, a};
    in_valid = v;
    tick();
  endtask

  // Raise rst mid-cycle, verify immediate clearing, release after one edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_out_valid[%0d]", k), 32'(out_valid[k]), 0);
      chk($sformatf("rst_in_ready[%0d]", k), 32'(in_ready[k]), 0);
      chk($sformatf("rst_z[%0d]", k), 32'($signed(z[k])), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    xs.delete();
    m_done = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      chk($sformatf("post_rst_in_ready[%0d]", k), 32'(in_ready[k]), 1);
  endtask

  task automatic std_neuron(input logic m);
    mode = m;
    out_ready = 1'b0;
    beat(8'd1, 8'd2, 1'b1);
    beat(8'd3, 8'd4, 1'b1);
    beat(8'd5, 8'd6, 1'b1);
    beat(8'd7, 8'd8, 1'b1);
  endtask

  initial begin
    wv[0] = WV0; wv[1] = WV1; wv[2] = WV2; wv[3] = WV3; wv[4] = WV4;
    bias[0] = 0; bias[1] = 0; bias[2] = 40; bias[3] = 0; bias[4] = -77;
    m_done = 1'b0; m_mode = 1'b0;
    rst = 1'b0; mode = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0;
    #1;
    async_reset();

    // Basic sum, negative weights, linear mode
    std_neuron(1'b0);
    chk("sum36", zval(0), 36);
    chk("neg36", zval(1), -36);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // ReLU mode
    std_neuron(1'b1);
    chk("relu_neg", zval(1), 0);
    chk("relu_bias40", zval(2), 4);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // Mode is sampled at beat 0 only
    mode = 1'b1;
    beat(8'd1, 8'd2, 1'b1);
    mode = 1'b0;
    beat(8'd3, 8'd4, 1'b1);
    beat(8'd5, 8'd6, 1'b1);
    beat(8'd7, 8'd8, 1'b1);
    chk("mode_held", zval(1), 0);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // Bubbles then backpressure with ignored extra beats
    mode = 1'b0; out_ready = 1'b0;
    beat(8'd1, 8'd2, 1'b1); beat(8'd99, 8'd99, 1'b0);
    beat(8'd3, 8'd4, 1'b1); beat(8'd99, 8'd99, 1'b0);
    beat(8'd5, 8'd6, 1'b1); beat(8'd99, 8'd99, 1'b0);
    beat(8'd7, 8'd8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      beat(8'($urandom), 8'($urandom), 1'b1);
      chk("bp_z_stable", zval(0), 36);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("bp_ov_drop", 32'(out_valid[0]), 0);
    out_ready = 1'b0;
    beat(8'd10, 8'd20, 1'b1); beat(8'd30, 8'd40, 1'b1);
    beat(8'd50, 8'd60, 1'b1); beat(8'd70, 8'd80, 1'b1);
    chk("next_neuron", zval(0), 360);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // Extremes
    mode = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(8'h80, 8'h80, 1'b1);
    chk("extreme", zval(3), 131072);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // Flush after two beats; beat in the flush cycle is dropped
    out_ready = 1'b0;
    beat(8'd100, 8'd100, 1'b1); beat(8'd100, 8'd100, 1'b1);
    flush = 1'b1;
    beat(8'd100, 8'd100, 1'b1);
    flush = 1'b0;
    std_neuron(1'b0);
    chk("flush", zval(0), 36);
    flush = 1'b1; in_valid = 1'b0;
    tick();
    chk("flush_in_done", zval(0), 36);
    flush = 1'b0; out_ready = 1'b1;
    tick();

    // Reset mid-neuron and while in DONE
    out_ready = 1'b0;
    beat(8'd9, 8'd9, 1'b1); beat(8'd9, 8'd9, 1'b1);
    async_reset();
    std_neuron(1'b0);
    chk("after_rst_mid", zval(0), 36);
    async_reset();
    std_neuron(1'b1);
    chk("after_rst_done", zval(2), 4);
    out_ready = 1'b1; in_valid = 1'b0;
    tick();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      in_data   = 16'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      mode      = ($urandom_range(0, 1) == 1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
